cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
// - Parametrised run/step/halt sequencer for the multi-cycle CPU.
// - Replaces hand-toggled reset in benches with a reusable, synthesizable controller.
// - Holds the CPU in reset for a programmable number of cycles, then gates the CPU clock-enable.
// - Supports free-run, single-instruction step, PC breakpoint, external halt and a cycle watchdog.
// - Sits between the bench/debug host and the CPU top (drives CPU Reset and clock-enable).
// PARAMETERS
// - ADDR_W     32  width of PC inputs and breakpoint address
// - CNT_W      32  width of cycle_cnt and instr_cnt
// - RST_HOLD   4   cycles CPU_Reset is held low after reset/soft_rst (>=1)
// - MAX_CYCLES 0   watchdog limit on run cycles since last start; 0 = watchdog disabled
// PORTS
// - CLK        in   1       clock; all state updates on rising edge
// - Reset      in   1       asynchronous, active-high controller reset
// - soft_rst   in   1       synchronous request to re-enter HOLD from any state
// - start      in   1       enter free-run from IDLE or HALT
// - step       in   1       execute exactly one instruction from IDLE or HALT
// - halt_req   in   1       stop a RUN at the next edge
// - bp_en      in   1       breakpoint enable
// - bp_addr    in   ADDR_W  breakpoint PC
// - instr_done in   1       CPU pulse: last cycle of an instruction (write-back)
// - nextPC     in   ADDR_W  CPU next-PC, valid when instr_done=1
// - CPU_Reset  out  1       to CPU Reset input; 0 = CPU held in reset, 1 = CPU released
// - CPU_En     out  1       CPU clock-enable; CPU state advances only when 1
// - state      out  3       HOLD=0 IDLE=1 RUN=2 STEP=3 HALT=4
// - bp_hit     out  1       sticky: last halt caused by breakpoint
// - timeout    out  1       sticky: last halt caused by watchdog
// - cycle_cnt  out  CNT_W   edges with CPU_En=1; saturates at all-ones
// - instr_cnt  out  CNT_W   instr_done pulses seen with CPU_En=1; saturates at all-ones
// BEHAVIOUR
// - All outputs registered.
// - Reset value of every output:
//   - state = HOLD, CPU_Reset = 0, CPU_En = 0
//   - bp_hit = 0, timeout = 0, cycle_cnt = 0, instr_cnt = 0
//   - Internal hold counter = 0, watchdog counter = 0.
// - HOLD:
//   - CPU_Reset = 0, CPU_En = 0.
//   - Hold counter increments each edge.
//   - The edge on which hold counter = RST_HOLD-1 moves to IDLE and sets CPU_Reset = 1.
//   - Result: CPU_Reset is low for exactly RST_HOLD cycles.
//   - start/step are ignored in HOLD.
// - IDLE / HALT:
//   - CPU_En = 0.
//   - start -> RUN. Otherwise step -> STEP. start has priority when both are asserted.
//   - Entering RUN or STEP clears bp_hit, timeout and the watchdog counter.
//   - CPU_En = 1 from the same edge (1-cycle latency from the sampled request).
// - RUN:
//   - CPU_En = 1. Halt conditions, in priority order:
//     - halt_req
//     - breakpoint: bp_en & instr_done & nextPC == bp_addr; sets bp_hit
//     - watchdog: MAX_CYCLES != 0 & watchdog counter == MAX_CYCLES-1; sets timeout
//   - Any halt condition -> HALT, CPU_En = 0 after that edge.
//   - The halting cycle itself is counted.
//   - A breakpoint stops before the instruction at bp_addr executes.
//   - Resuming executes the instruction at bp_addr; there is no re-hit unless the PC returns to bp_addr.
// - STEP:
//   - CPU_En = 1 until instr_done, then -> HALT.
//   - halt_req aborts to HALT mid-instruction.
//   - Breakpoint and watchdog are evaluated as in RUN.
// - Counters:
//   - cycle_cnt and the watchdog counter increment on every edge with CPU_En = 1.
//   - instr_cnt increments on instr_done & CPU_En.
//   - All counters saturate; they never wrap.
//   - Counters clear only on Reset or soft_rst.
// - soft_rst has priority over all other inputs:
//   - -> HOLD, CPU_En = 0, CPU_Reset = 0.
//   - Hold counter, counters and flags are cleared.
// - Reset mid-operation (async) takes effect immediately, without waiting for an edge: reset values apply.
// - instr_done while CPU_En = 0 is ignored.
// TESTING
// - Reset released, RST_HOLD=4, no inputs
//   -> CPU_Reset low exactly 4 cycles; state=IDLE; CPU_En=0; counters 0.
// - start pulse in IDLE, 3-cycle instructions, halt_req after 10 enabled cycles
//   -> cycle_cnt=11, instr_cnt=3, state=HALT, bp_hit=0.
// - bp_en=1, bp_addr=0x0000000C, PC increments by 4, start
//   -> halt on instr_done with nextPC=0x0C, instr_cnt=3, bp_hit=1.
// - Then start again
//   -> bp_hit clears and the run continues past 0x0C.
// - step from HALT with a 4-cycle instruction
//   -> CPU_En high exactly 4 cycles, instr_cnt +1, state=HALT.
// - start and step asserted on the same edge -> RUN.
// - MAX_CYCLES=20, run with no halt
//   -> HALT after 20 enabled cycles, timeout=1.
// - soft_rst in RUN -> HOLD next edge, counters 0.
// - Async Reset asserted between edges mid-RUN -> CPU_En=0 immediately.
// - CNT_W=4, long run -> cycle_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the debug host / CPU side and the run controller.
// master = host and CPU side, slave = cpu_run_ctrl.
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              soft_rst;
    logic              start;
    logic              step;
    logic              halt_req;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic              instr_done;
    logic [ADDR_W-1:0] nextPC;
    logic              CPU_Reset;
    logic              CPU_En;
    logic [2:0]        state;
    logic              bp_hit;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        output soft_rst, start, step, halt_req, bp_en, bp_addr, instr_done, nextPC,
        input  CPU_Reset, CPU_En, state, bp_hit, timeout, cycle_cnt, instr_cnt
    );

    modport slave (
        input  soft_rst, start, step, halt_req, bp_en, bp_addr, instr_done, nextPC,
        output CPU_Reset, CPU_En, state, bp_hit, timeout, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the multi-cycle CPU: reset hold, clock-enable gating,
// PC breakpoint, external halt, cycle watchdog and saturating activity counters.
//
// state | meaning
// HOLD  | CPU held in reset for RST_HOLD cycles
// IDLE  | CPU released, clock-enable off, waiting for start/step
// RUN   | free-running until halt_req, breakpoint or watchdog
// STEP  | running until the current instruction completes
// HALT  | stopped; start/step resume
module cpu_run_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RST_HOLD   = 4,
    parameter int MAX_CYCLES = 0
) (
    input logic           i_clk,
    input logic           i_rst,
    cpu_run_ctrl_if.slave io_ctl
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam int WD_W = 32;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);
    localparam bit WD_ON = (MAX_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_IDLE = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt,  w_hold_nxt;
    logic              r_cpu_reset, w_cpu_reset_nxt;
    logic              r_cpu_en,    w_cpu_en_nxt;
    logic              r_bp_hit,    w_bp_hit_nxt;
    logic              r_timeout,   w_timeout_nxt;
    logic [WD_W-1:0]   r_wd_cnt,    w_wd_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt, w_cycle_nxt;
    logic [CNT_W-1:0]  r_instr_cnt, w_instr_nxt;

    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_bp_addr;
    logic              w_bp_match;
    logic              w_wd_hit;

    assign w_next_pc  = io_ctl.nextPC;
    assign w_bp_addr  = io_ctl.bp_addr;
    assign w_bp_match = io_ctl.bp_en && io_ctl.instr_done && (w_next_pc == w_bp_addr);
    assign w_wd_hit   = WD_ON && (r_wd_cnt == WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_cpu_reset <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_cpu_en    <= w_cpu_en_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
            r_timeout   <= w_timeout_nxt;
            r_wd_cnt    <= w_wd_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_instr_cnt <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_bp_hit_nxt  = r_bp_hit;
        w_timeout_nxt = r_timeout;
        w_wd_nxt      = r_wd_cnt;
        w_cycle_nxt   = r_cycle_cnt;
        w_instr_nxt   = r_instr_cnt;

        // the cycle that ends at this edge is counted, including a halting one
        if (r_cpu_en) begin
            if (r_cycle_cnt != '1) w_cycle_nxt = r_cycle_cnt + CNT_W'(1);
            if (r_wd_cnt != '1)    w_wd_nxt    = r_wd_cnt + WD_W'(1);
            if (io_ctl.instr_done && (r_instr_cnt != '1)) w_instr_nxt = r_instr_cnt + CNT_W'(1);
        end

        case (r_state)
            ST_HOLD: begin
                w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end
            end
            ST_IDLE, ST_HALT: begin
                if (io_ctl.start || io_ctl.step) begin
                    w_state_nxt   = io_ctl.start ? ST_RUN : ST_STEP;
                    w_bp_hit_nxt  = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_wd_nxt      = '0;
                end
            end
            ST_RUN, ST_STEP: begin
                if (io_ctl.halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (w_bp_match) begin
                    w_state_nxt  = ST_HALT;
                    w_bp_hit_nxt = 1'b1;
                end else if (w_wd_hit) begin
                    w_state_nxt   = ST_HALT;
                    w_timeout_nxt = 1'b1;
                end else if ((r_state == ST_STEP) && io_ctl.instr_done) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_HOLD;
        endcase

        if (io_ctl.soft_rst) begin
            w_state_nxt   = ST_HOLD;
            w_hold_nxt    = '0;
            w_bp_hit_nxt  = 1'b0;
            w_timeout_nxt = 1'b0;
            w_wd_nxt      = '0;
            w_cycle_nxt   = '0;
            w_instr_nxt   = '0;
        end

        w_cpu_reset_nxt = (w_state_nxt != ST_HOLD);
        w_cpu_en_nxt    = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
    end

    assign io_ctl.state     = r_state;
    assign io_ctl.CPU_Reset = r_cpu_reset;
    assign io_ctl.CPU_En    = r_cpu_en;
    assign io_ctl.bp_hit    = r_bp_hit;
    assign io_ctl.timeout   = r_timeout;
    assign io_ctl.cycle_cnt = r_cycle_cnt;
    assign io_ctl.instr_cnt = r_instr_cnt;
endmodule
